adc_reader: RTL and testbench
=============================

# adc_reader

SPI master that reads a 10-bit two-channel ADC (MCP3002-style framing) and returns samples to the fabric. It is the read-side counterpart of the DAC writer on the same board. Both blocks share the `ipControl` run/stop convention, so one controller can start and stop generation and acquisition together. SCK is produced from `ipClk` with a tick enable; no derived clock is used internally.

## Interface
- `CLK_DIV`, default 4: `ipClk` cycles per SCK half-period. Must be ≥2.
- `GAP_HALF`, default 2: number of SCK half-periods `opCS` stays high between frames. Must be ≥1.
- `ipClk`, in, 1: system clock. All logic is on the rising edge.
- `ipReset`, in, 1: asynchronous, active-high reset.
- `ipControl`, in, 2: `2'b01` = run continuous conversions; `2'b10` = stop; `00`/`11` = keep the current mode.
- `ipChannel`, in, 1: ADC channel to convert. Sampled at frame start.
- `ipMISO`, in, 1: serial data from the ADC.
- `opSCK`, out, 1: SPI clock. Idles low.
- `opCS`, out, 1: chip select, active low.
- `opMOSI`, out, 1: serial command to the ADC.
- `opData`, out, 10: last completed sample.
- `opValid`, out, 1: one-`ipClk` pulse when `opData` updates.

## Operation
- Tick: a free-running divider counts 0..`CLK_DIV`-1. A tick occurs on the cycle the count equals `CLK_DIV`-1. All state, SCK, CS and MOSI changes happen only on ticks.
- States are Stop, Setup, Shift and Gap.
  - **Stop:**
    - Outputs: `opCS`=1, `opSCK`=0, `opMOSI`=0.
    - On a tick with `ipControl`==01: latch `ipChannel`, drive `opCS`=0 and `opMOSI`=1 (start bit), clear the half-period index `h`, go to Setup.
  - **Setup:** lasts one half-period with SCK low (CS-to-SCK setup time). On the next tick go to Shift with `h`=0.
  - **Shift:** 32 half-periods, `h`=0..31. Bit index is `k`=`h`/2.
    - Even `h`: SCK high.
    - Odd `h`: SCK low, and `opMOSI` takes command bit `k`+1.
    - The tick ending each high phase (even `h`) samples `ipMISO` into shift-register bit `k`.
  - **Gap:**
    - On entry: `opCS`=1 and `opMOSI`=0.
    - Stays for `GAP_HALF` half-periods.
    - On exit: if the mode is run, go to Setup, re-latch `ipChannel` and drive `opMOSI`=1. If the mode is stop, go to Stop.
- Command word, 16 bits, MSB first on `k`=0..15: {1 start, 1 single-ended, channel, 1 MSB-first, 12'b0}. Channel 0 gives 0xD000; channel 1 gives 0xF000.
- Response bits by `k`:
  - `k`=0..3: ignored (config phase).
  - `k`=4: null bit, ignored.
  - `k`=5..14: D9..D0.
  - `k`=15: ignored.
- Completion: on the tick that leaves Shift, `opData` is loaded with D9..D0 and `opValid`=1 for exactly that `ipClk` cycle.
- Mode register:
  - Set by `ipControl`==01 and cleared by 10, on any cycle.
  - A stop request never aborts a frame. The frame in flight completes, delivers its `opValid`, and the block then goes Gap → Stop.
  - If stop and run both arrive within one frame, the last value seen before Gap exit wins.
- Channel: a change on `ipChannel` mid-frame affects only the next frame.

## Timing
- Reset values: `opCS`=1, `opSCK`=0, `opMOSI`=0, `opData`=0, `opValid`=0, state Stop, divider=0, `h`=0, mode=stop.
- Reset mid-frame: all outputs take their reset values immediately (asynchronously). No `opValid` is produced for the aborted frame.
- Start latency: at most `CLK_DIV` `ipClk` cycles from `ipControl`==01 to `opCS` falling (waits for the next tick).
- First SCK rising edge: `CLK_DIV` cycles after `opCS` falls.
- `opValid`: asserts 33·`CLK_DIV` cycles after `opCS` falls. With defaults that is 132.
- `opCS` rises on the same cycle as `opValid`.
- Continuous mode period: (33+`GAP_HALF`)·`CLK_DIV` cycles between `opValid` pulses. With defaults that is 140.
- SCK frequency: `ipClk`/(2·`CLK_DIV`). Duty cycle is 50%.
- Setup-to-sample margin: MISO is sampled one full half-period after the rising edge, and MOSI is stable for a full high phase.

## Test plan
- **Reset:** assert `ipReset` with `ipControl`=01 held → all outputs at reset values, no SCK toggling. Release reset → `opCS` falls within 4 cycles.
- **Single conversion, channel 1:** ADC model returns 0x2A5 and drives 1 on the null bit → MOSI frame captured as 0xF000, exactly 16 SCK rising edges, `opData`=0x2A5, one `opValid` 132 cycles after `opCS` falls.
- **Continuous run, channel 0:** ADC returns 0x3FF then 0x000 then 0x155 → MOSI 0xD000 each frame, `opValid` pulses spaced 140 cycles, `opData` follows 0x3FF, 0x000, 0x155.
- **Stop mid-frame:** `ipControl`=10 at `h`=10 → frame completes with `opValid`, `opCS` high, block in Stop, no further SCK.
- **Channel change mid-frame:** `ipChannel` 0→1 at `h`=6 → current MOSI stays 0xD000, next frame is 0xF000.
- **Reset mid-Shift:** pulse `ipReset` at `h`=20 → immediate `opCS`=1, `opSCK`=0, `opData` unchanged at 0, no `opValid`. Restart produces a clean full 16-bit frame.

Source files
------------

// File: rtl/adc_reader.sv
// adc_reader: SPI master that reads an MCP3002-style 10-bit two-channel ADC.
// SCK, CS and MOSI are registered and only change on divider ticks; no derived clock.
module adc_reader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned GAP_HALF = 2
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic [1:0] ipControl,
    input  logic       ipChannel,
    input  logic       ipMISO,
    output logic       opSCK,
    output logic       opCS,
    output logic       opMOSI,
    output logic [9:0] opData,
    output logic       opValid
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W   = (GAP_HALF > 32) ? $clog2(GAP_HALF) : 5;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(31);
    localparam logic [H_W-1:0]   GAP_LAST = H_W'(GAP_HALF - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;
    logic             mode_q, mode_d;
    logic             chan_q, chan_d;
    logic [10:0]      sr_q, sr_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic [9:0]       data_q, data_d;
    logic             valid_q, valid_d;

    logic             tick_c;
    logic [15:0]      cmd_word_c;
    logic [3:0]       k_c;

    assign tick_c     = (div_q == DIV_LAST);
    assign cmd_word_c = {1'b1, 1'b1, chan_q, 1'b1, 12'h000};
    assign k_c        = h_q[4:1];

    // Next-state logic; the shift register keeps only response bits k=5..15,
    // so after the last sample bits [10:1] hold D9..D0.
    always_comb begin
        state_d = state_q;
        div_d   = tick_c ? '0 : div_q + 1'b1;
        h_d     = h_q;
        mode_d  = mode_q;
        chan_d  = chan_q;
        sr_d    = sr_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        data_d  = data_q;
        valid_d = 1'b0;

        case (ipControl)
            2'b01:   mode_d = 1'b1;
            2'b10:   mode_d = 1'b0;
            default: mode_d = mode_q;
        endcase

        if (tick_c) begin
            case (state_q)
                ST_STOP: begin
                    if (mode_d) begin
                        state_d = ST_SETUP;
                        chan_d  = ipChannel;
                        cs_d    = 1'b0;
                        mosi_d  = 1'b1;
                        h_d     = '0;
                    end
                end
                ST_SETUP: begin
                    state_d = ST_SHIFT;
                    h_d     = '0;
                    sck_d   = 1'b1;
                end
                ST_SHIFT: begin
                    if (!h_q[0]) begin
                        sck_d  = 1'b0;
                        sr_d   = {sr_q[9:0], ipMISO};
                        mosi_d = (k_c == 4'd15) ? 1'b0 : cmd_word_c[4'd14 - k_c];
                        h_d    = h_q + 1'b1;
                    end else if (h_q == H_LAST) begin
                        state_d = ST_GAP;
                        h_d     = '0;
                        data_d  = sr_q[10:1];
                        valid_d = 1'b1;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        sck_d = 1'b1;
                        h_d   = h_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (h_q == GAP_LAST) begin
                        h_d = '0;
                        if (mode_d) begin
                            state_d = ST_SETUP;
                            chan_d  = ipChannel;
                            cs_d    = 1'b0;
                            mosi_d  = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            h_q     <= '0;
            mode_q  <= 1'b0;
            chan_q  <= 1'b0;
            sr_q    <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            h_q     <= h_d;
            mode_q  <= mode_d;
            chan_q  <= chan_d;
            sr_q    <= sr_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign opSCK   = sck_q;
    assign opCS    = cs_q;
    assign opMOSI  = mosi_q;
    assign opData  = data_q;
    assign opValid = valid_q;

endmodule

// File: tb/tb_adc_reader.sv
// Scoreboard bench for adc_reader: stimulus queues expected samples and commands,
// a negedge monitor plays the ADC and checks every opValid against the queue.
module tb_adc_reader;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned GAP_HALF = 2;
    localparam int LAT    = 33 * CLK_DIV;
    localparam int PERIOD = (33 + GAP_HALF) * CLK_DIV;

    typedef struct {
        logic [9:0]  data;
        logic [15:0] cmd;
        bit          chained;
    } exp_t;

    logic       clk = 1'b0;
    logic       ipReset;
    logic [1:0] ipControl;
    logic       ipChannel;
    logic       ipMISO = 1'b0;
    logic       opSCK, opCS, opMOSI, opValid;
    logic [9:0] opData;

    exp_t        exp_q[$];
    logic [15:0] adc_q[$];

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          cs_fall_cyc = 0;
    int          last_valid_cyc = -1;
    int          edges = 0;
    int          cs_falls = 0;
    int          sck_rises = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    logic [15:0] cmd_cap = '0;
    logic [15:0] cur_word = '0;

    adc_reader #(.CLK_DIV(CLK_DIV), .GAP_HALF(GAP_HALF)) dut (
        .ipClk    (clk),
        .ipReset  (ipReset),
        .ipControl(ipControl),
        .ipChannel(ipChannel),
        .ipMISO   (ipMISO),
        .opSCK    (opSCK),
        .opCS     (opCS),
        .opMOSI   (opMOSI),
        .opData   (opData),
        .opValid  (opValid)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, req);
        end
    endfunction

    // Command from the field definition: start, single-ended, channel, MSB-first, zeros.
    function automatic logic [15:0] ref_cmd(input logic ch);
        return {1'b1, 1'b1, ch, 1'b1, 12'h000};
    endfunction

    // Response word as the ADC sends it, bit k at position 15-k: 4 junk, null, D9..D0, junk.
    task automatic issue_frame(input logic [9:0] v, input logic ch, input bit chained,
                               input logic nullb);
        logic [15:0] word;
        exp_t e;
        word = {4'($urandom), nullb, v, 1'($urandom)};
        adc_q.push_back(word);
        e.data = v;
        e.cmd = ref_cmd(ch);
        e.chained = chained;
        exp_q.push_back(e);
    endtask

    // ADC model and checker, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (ipReset) begin
            edges    <= 0;
            prev_cs  <= 1'b1;
            prev_sck <= 1'b0;
            ipMISO   <= 1'b0;
        end else begin
            if (prev_cs && !opCS) begin
                cs_fall_cyc = cyc;
                edges = 0;
                cmd_cap = '0;
                cs_falls++;
                cur_word = (adc_q.size() != 0) ? adc_q.pop_front() : 16'h0000;
            end
            if (!prev_sck && opSCK) begin
                cmd_cap = {cmd_cap[14:0], opMOSI};
                if (edges < 16) ipMISO <= cur_word[15 - edges];
                edges++;
                sck_rises++;
            end
            if (opValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data", opData, e.data);
                    chk("mosi_cmd", cmd_cap, e.cmd);
                    chk("sck_rises", edges, 16);
                    chk("valid_latency", cyc - cs_fall_cyc, LAT);
                    chk("cs_high_at_valid", opCS, 1);
                    if (e.chained) chk("valid_period", cyc - last_valid_cyc, PERIOD);
                end
                last_valid_cyc = cyc;
            end
            prev_cs  <= opCS;
            prev_sck <= opSCK;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ctrl(input logic [1:0] c);
        ipControl = c;
        step(1);
        ipControl = 2'b00;
    endtask

    task automatic wait_falls(input int target);
        int n = 0;
        while (cs_falls < target && n < 2000) begin
            step(1);
            n++;
        end
        if (cs_falls < target) chk("cs_fall_timeout", cs_falls, target);
    endtask

    task automatic wait_edges(input int target);
        int n = 0;
        while (edges < target && n < 500) begin
            step(1);
            n++;
        end
        if (edges < target) chk("sck_timeout", edges, target);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        int s;
        int f;
        s = sck_rises;
        f = cs_falls;
        step(200);
        chk({name, "_no_sck"}, sck_rises - s, 0);
        chk({name, "_no_frame"}, cs_falls - f, 0);
        chk({name, "_cs_high"}, opCS, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, wanted fewer", cyc);
        $fatal(1);
    end

    initial begin
        int rst_bad;
        int n;
        int base;
        logic ch;

        ipReset   = 1'b1;
        ipControl = 2'b01;
        ipChannel = 1'b1;
        rst_bad   = 0;
        repeat (10) begin
            @(negedge clk);
            if (opCS !== 1'b1 || opSCK !== 1'b0 || opMOSI !== 1'b0 ||
                opValid !== 1'b0 || opData !== 10'h000) rst_bad++;
        end
        chk("reset_outputs", rst_bad, 0);

        // Single conversion on channel 1, run held through reset release.
        issue_frame(10'h2A5, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        ipReset = 1'b0;
        n = 0;
        while (opCS && n < 20) begin
            step(1);
            n++;
        end
        chk("start_latency_ok", (n >= 1 && n <= int'(CLK_DIV)) ? 1 : 0, 1);
        pulse_ctrl(2'b10);
        wait_drain();
        check_idle("single");

        // Continuous run on channel 0 with three known samples.
        ipChannel = 1'b0;
        base = cs_falls;
        issue_frame(10'h3FF, 1'b0, 1'b0, 1'($urandom));
        issue_frame(10'h000, 1'b0, 1'b1, 1'($urandom));
        issue_frame(10'h155, 1'b0, 1'b1, 1'($urandom));
        pulse_ctrl(2'b01);
        wait_falls(base + 3);
        pulse_ctrl(2'b10);
        wait_drain();
        check_idle("cont");

        // Stop request in the middle of a frame still completes that frame.
        ch = 1'($urandom);
        ipChannel = ch;
        base = cs_falls;
        issue_frame(10'($urandom), ch, 1'b0, 1'($urandom));
        pulse_ctrl(2'b01);
        wait_falls(base + 1);
        wait_edges(6);
        pulse_ctrl(2'b10);
        wait_drain();
        check_idle("stop_mid");

        // Channel change mid-frame only affects the following frame.
        ipChannel = 1'b0;
        base = cs_falls;
        issue_frame(10'($urandom), 1'b0, 1'b0, 1'($urandom));
        issue_frame(10'($urandom), 1'b1, 1'b1, 1'($urandom));
        pulse_ctrl(2'b01);
        wait_falls(base + 1);
        wait_edges(4);
        ipChannel = 1'b1;
        wait_falls(base + 2);
        pulse_ctrl(2'b10);
        wait_drain();
        check_idle("chan_change");

        // Randomised continuous run.
        ch = 1'($urandom);
        ipChannel = ch;
        base = cs_falls;
        for (int i = 0; i < 5; i++) begin
            issue_frame(10'($urandom), ch, (i != 0), 1'($urandom));
        end
        pulse_ctrl(2'b01);
        wait_falls(base + 5);
        pulse_ctrl(2'b10);
        wait_drain();
        check_idle("random_run");

        // Reset in the middle of Shift aborts the frame without a sample.
        ipChannel = 1'b1;
        base = cs_falls;
        adc_q.push_back(16'($urandom));
        pulse_ctrl(2'b01);
        wait_falls(base + 1);
        wait_edges(11);
        ipReset = 1'b1;
        #1;
        chk("midreset_cs", opCS, 1);
        chk("midreset_sck", opSCK, 0);
        chk("midreset_valid", opValid, 0);
        chk("midreset_data", opData, 0);
        step(3);
        ipReset = 1'b0;
        step(10);
        chk("after_reset_stopped", opCS, 1);
        adc_q.delete();
        base = cs_falls;
        issue_frame(10'($urandom), 1'b1, 1'b0, 1'($urandom));
        pulse_ctrl(2'b01);
        wait_falls(base + 1);
        pulse_ctrl(2'b10);
        wait_drain();
        check_idle("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
